// File: rtl/cmi_arb_pkg.sv
// Shared definitions for the CMI bus arbiter: state encoding, requester
// indices and default timeout/starvation limits.
package cmi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [1:0] REQ_CPU = 2'd0;
    localparam logic [1:0] REQ_1   = 2'd1;
    localparam logic [1:0] REQ_2   = 2'd2;
    localparam logic [1:0] REQ_3   = 2'd3;

    localparam int unsigned GRANT_TMO_DEF  = 15;
    localparam int unsigned BUSY_TMO_DEF   = 255;
    localparam int unsigned STARVE_MAX_DEF = 8;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmi_arb_prio.sv
// Combinational priority select: highest-index active request wins unless the
// CPU is being starved, in which case the CPU wins.
module cmi_arb_prio
    import cmi_arb_pkg::*;
(
    input  logic [3:0] req_l,
    input  logic       starve_h,
    output logic [1:0] winner,
    output logic       valid
);

    always_comb begin
        winner = REQ_CPU;
        valid  = ~&req_l;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!req_l[i]) winner = 2'(i);
        end
        if (starve_h && !req_l[REQ_CPU]) winner = REQ_CPU;
    end

endmodule

// File: rtl/cmi_bus_arbiter.sv
// CMI bus arbiter: grants one requester at a time, tracks the bus tenure and
// withdraws unused grants or overlong tenures with one-cycle timeout pulses.
module cmi_bus_arbiter
    import cmi_arb_pkg::*;
#(
    parameter int unsigned GRANT_TMO  = GRANT_TMO_DEF,
    parameter int unsigned BUSY_TMO   = BUSY_TMO_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       b_clk_l,
    input  logic       mseq_init_h,
    input  logic [3:0] req_l,
    input  logic       dbbz_l,
    input  logic       hold_l,
    output logic [3:0] grant_l,
    output logic       arb_busy_h,
    output logic       grant_tmo_h,
    output logic       bus_tmo_h,
    output logic [1:0] owner_h
);

    localparam logic [7:0] GRANT_LIM  = 8'(GRANT_TMO);
    localparam logic [7:0] BUSY_LIM   = 8'(BUSY_TMO);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_t state;
    logic [7:0] grant_cnt;
    logic [7:0] busy_cnt;
    logic [7:0] starve_cnt;
    logic       starve_h;
    logic [1:0] winner;
    logic       req_valid;

    assign starve_h = (starve_cnt == STARVE_LIM);

    cmi_arb_prio u_prio (
        .req_l    (req_l),
        .starve_h (starve_h),
        .winner   (winner),
        .valid    (req_valid)
    );

    always_ff @(posedge b_clk_l or posedge mseq_init_h) begin
        if (mseq_init_h) begin
            state       <= ST_IDLE;
            grant_l     <= '1;
            arb_busy_h  <= 1'b0;
            grant_tmo_h <= 1'b0;
            bus_tmo_h   <= 1'b0;
            owner_h     <= '0;
            grant_cnt   <= '0;
            busy_cnt    <= '0;
            starve_cnt  <= '0;
        end else begin
            grant_tmo_h <= 1'b0;
            bus_tmo_h   <= 1'b0;
            if (req_l[REQ_CPU]) starve_cnt <= '0;

            case (state)
                ST_IDLE: begin
                    if (req_valid && dbbz_l && hold_l) begin
                        state      <= ST_GRANT;
                        arb_busy_h <= 1'b1;
                        grant_l    <= ~(4'b0001 << winner);
                        owner_h    <= winner;
                        grant_cnt  <= '0;
                        busy_cnt   <= '0;
                        if (winner == REQ_CPU)
                            starve_cnt <= '0;
                        else if (!req_l[REQ_CPU] && starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 8'd1;
                    end
                end
                ST_GRANT: begin
                    grant_cnt <= sat_inc(grant_cnt);
                    // Bus activity outranks a same-cycle request withdrawal.
                    if (!dbbz_l) begin
                        state     <= ST_BUSY;
                        grant_l   <= '1;
                        grant_cnt <= '0;
                        busy_cnt  <= '0;
                    end else if (req_l[owner_h]) begin
                        state      <= ST_IDLE;
                        grant_l    <= '1;
                        arb_busy_h <= 1'b0;
                    end else if (sat_inc(grant_cnt) == GRANT_LIM) begin
                        state       <= ST_IDLE;
                        grant_l     <= '1;
                        arb_busy_h  <= 1'b0;
                        grant_tmo_h <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (dbbz_l && hold_l) begin
                        state <= ST_DRAIN;
                    end else begin
                        busy_cnt <= sat_inc(busy_cnt);
                        if (sat_inc(busy_cnt) == BUSY_LIM) begin
                            state     <= ST_DRAIN;
                            bus_tmo_h <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_IDLE;
                    arb_busy_h <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    grant_l    <= '1;
                    arb_busy_h <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmi_bus_arbiter.sv
// Directed and randomized bench for cmi_bus_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_cmi_bus_arbiter;

    localparam int GRANT_TMO  = 15;
    localparam int BUSY_TMO   = 255;
    localparam int STARVE_MAX = 8;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_BUSY  = 2;
    localparam int M_DRAIN = 3;

    logic       b_clk_l = 1'b0;
    logic       mseq_init_h;
    logic [3:0] req_l;
    logic       dbbz_l;
    logic       hold_l;
    logic [3:0] grant_l;
    logic       arb_busy_h;
    logic       grant_tmo_h;
    logic       bus_tmo_h;
    logic [1:0] owner_h;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_mode   = M_IDLE;
    int m_owner  = 0;
    int m_age    = 0;
    int m_starve = 0;
    bit m_gtmo   = 1'b0;
    bit m_btmo   = 1'b0;

    cmi_bus_arbiter #(
        .GRANT_TMO  (GRANT_TMO),
        .BUSY_TMO   (BUSY_TMO),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .b_clk_l     (b_clk_l),
        .mseq_init_h (mseq_init_h),
        .req_l       (req_l),
        .dbbz_l      (dbbz_l),
        .hold_l      (hold_l),
        .grant_l     (grant_l),
        .arb_busy_h  (arb_busy_h),
        .grant_tmo_h (grant_tmo_h),
        .bus_tmo_h   (bus_tmo_h),
        .owner_h     (owner_h)
    );

    always #5 b_clk_l = ~b_clk_l;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick_winner();
        int w = 0;
        for (int i = 3; i >= 0; i--) begin
            if (!req_l[i]) begin
                w = i;
                break;
            end
        end
        if (!req_l[0] && m_starve == STARVE_MAX) w = 0;
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_owner = 0; m_age = 0; m_starve = 0;
        m_gtmo = 1'b0;   m_btmo = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        m_gtmo = 1'b0;
        m_btmo = 1'b0;
        if (req_l[0]) m_starve = 0;
        case (m_mode)
            M_IDLE: if (req_l != 4'hF && dbbz_l && hold_l) begin
                w = pick_winner();
                m_mode = M_GRANT; m_owner = w; m_age = 0;
                if (w == 0) m_starve = 0;
                else if (!req_l[0]) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
            end
            M_GRANT: begin
                m_age++;
                if (!dbbz_l) begin
                    m_mode = M_BUSY; m_age = 0;
                end else if (req_l[m_owner]) begin
                    m_mode = M_IDLE;
                end else if (m_age >= GRANT_TMO) begin
                    m_mode = M_IDLE; m_gtmo = 1'b1;
                end
            end
            M_BUSY: begin
                if (dbbz_l && hold_l) m_mode = M_DRAIN;
                else begin
                    m_age++;
                    if (m_age >= BUSY_TMO) begin
                        m_mode = M_DRAIN; m_btmo = 1'b1;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        logic [3:0] eg = 4'hF;
        if (m_mode == M_GRANT) eg[m_owner] = 1'b0;
        check("grant_l",     8'(grant_l),     8'(eg));
        check("arb_busy_h",  8'(arb_busy_h),  8'(m_mode != M_IDLE));
        check("grant_tmo_h", 8'(grant_tmo_h), 8'(m_gtmo));
        check("bus_tmo_h",   8'(bus_tmo_h),   8'(m_btmo));
        check("owner_h",     8'(owner_h),     8'(m_owner));
    endtask

    task automatic tick();
        @(posedge b_clk_l);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset pulse between clock edges; outputs must settle before the next edge.
    task automatic mid_reset();
        #2 mseq_init_h = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_grant", 8'(grant_l), 8'hF);
        mseq_init_h = 1'b0;
    endtask

    initial begin
        mseq_init_h = 1'b1;
        req_l = 4'hF; dbbz_l = 1'b1; hold_l = 1'b1;
        #12;
        check_all();
        check("por_grant", 8'(grant_l), 8'hF);
        mseq_init_h = 1'b0;

        // Basic grant then bus takeover
        req_l = 4'b1010;
        tick();
        check("basic_grant", 8'(grant_l), 8'(4'b1011));
        check("basic_owner", 8'(owner_h), 8'd2);
        dbbz_l = 1'b0;
        tick();
        check("basic_busy_grant", 8'(grant_l), 8'hF);
        check("basic_busy", 8'(arb_busy_h), 8'd1);
        dbbz_l = 1'b1; req_l = 4'hF;
        tick(); tick();

        // Unused grant withdrawn after GRANT_TMO cycles
        mid_reset();
        req_l = 4'b1101;
        tick();
        for (int k = 1; k < GRANT_TMO; k++) tick();
        check("gtmo_grant_held", 8'(grant_l), 8'(4'b1101));
        tick();
        check("gtmo_pulse", 8'(grant_tmo_h), 8'd1);
        check("gtmo_idle", 8'(arb_busy_h), 8'd0);
        req_l = 4'hF;
        tick();
        check("gtmo_once", 8'(grant_tmo_h), 8'd0);

        // Release before bus use: no timeout pulse
        req_l = 4'b1011;
        tick(); tick();
        req_l = 4'hF;
        tick();
        check("release_no_tmo", 8'(grant_tmo_h), 8'd0);
        check("release_idle", 8'(arb_busy_h), 8'd0);

        // Overlong tenure
        mid_reset();
        req_l = 4'b0111;
        tick();
        dbbz_l = 1'b0;
        tick();
        for (int k = 1; k < BUSY_TMO; k++) tick();
        tick();
        check("btmo_pulse", 8'(bus_tmo_h), 8'd1);
        check("btmo_drain_busy", 8'(arb_busy_h), 8'd1);
        tick();
        check("btmo_once", 8'(bus_tmo_h), 8'd0);
        check("btmo_idle", 8'(arb_busy_h), 8'd0);
        dbbz_l = 1'b1; req_l = 4'hF;
        tick();

        // CPU starvation override on the ninth tenure
        mid_reset();
        req_l = 4'b0110;
        for (int t = 0; t < 9; t++) begin
            tick();
            check("starve_grant", 8'(grant_l), (t < 8) ? 8'(4'b0111) : 8'(4'b1110));
            dbbz_l = 1'b0; tick();
            dbbz_l = 1'b1; tick();
            tick();
        end
        req_l = 4'hF;

        // Hold extends tenure, then one dead cycle before next grant
        mid_reset();
        req_l = 4'b1011;
        tick();
        dbbz_l = 1'b0; tick();
        dbbz_l = 1'b1; hold_l = 1'b0;
        tick(); tick(); tick();
        check("hold_busy", 8'(arb_busy_h), 8'd1);
        hold_l = 1'b1;
        tick();
        check("drain_grant", 8'(grant_l), 8'hF);
        check("drain_busy", 8'(arb_busy_h), 8'd1);
        tick();
        check("dead_cycle", 8'(grant_l), 8'hF);
        tick();
        check("next_grant", 8'(grant_l), 8'(4'b1011));
        req_l = 4'hF; tick();

        // Reset during GRANT and during BUSY
        mid_reset();
        req_l = 4'b0111;
        tick();
        mid_reset();
        check("rst_in_grant_busy", 8'(arb_busy_h), 8'd0);
        tick();
        dbbz_l = 1'b0;
        tick();
        mid_reset();
        check("rst_in_busy_busy", 8'(arb_busy_h), 8'd0);
        tick();
        check("rst_no_btmo", 8'(bus_tmo_h), 8'd0);
        dbbz_l = 1'b1; req_l = 4'hF;
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_l  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req_l = 4'hF;
            dbbz_l = ($urandom_range(0, 2) != 0);
            hold_l = ($urandom_range(0, 5) != 0);
            if (n % 997 == 500) mid_reset();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmi_bus_arbiter.md
CMI_BUS_ARBITER -- requirements
Module: cmi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter GRANT_TMO, default 15: cycles a grant may stay unused before it is withdrawn.
REQ-002 The block SHALL have parameter BUSY_TMO, default 255: maximum cycles DBBZ may stay asserted in one tenure.
REQ-003 The block SHALL have parameter STARVE_MAX, default 8: consecutive non-CPU grants allowed while the CPU waits.
REQ-004 The block SHALL have port b_clk_l, input, 1 bit: bus clock; all flops update on its rising edge.
REQ-005 The block SHALL have port mseq_init_h, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_l, input, 4 bits: bus requests, active-low; bit 0 is the CPU, bit 3 has highest priority.
REQ-007 The block SHALL have port dbbz_l, input, 1 bit: CMI bus busy, active-low.
REQ-008 The block SHALL have port hold_l, input, 1 bit: CMI hold, active-low; an asserted hold extends the current tenure.
REQ-009 The block SHALL have port grant_l, output, 4 bits: one-hot-low grants; bit 0 feeds the CPU's cmi_cpu_priority_l.
REQ-010 The block SHALL have port arb_busy_h, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port grant_tmo_h, output, 1 bit: one-cycle pulse when an unused grant is withdrawn.
REQ-012 The block SHALL have port bus_tmo_h, output, 1 bit: one-cycle pulse when a tenure exceeds BUSY_TMO.
REQ-013 The block SHALL have port owner_h, output, 2 bits: index of the current or last bus owner.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, GRANT, BUSY and DRAIN.
REQ-015 IDLE SHALL go to GRANT when any req_l bit is low, dbbz_l=1 and hold_l=1; in that case grant_l[winner] SHALL go low in the same registered update.
REQ-016 The winner SHALL be the highest-index requester, except as REQ-017 states.
REQ-017 When req_l[0]=0 and the starvation counter equals STARVE_MAX, the winner SHALL be 0.
REQ-018 The starvation counter SHALL increment on each non-CPU grant while req_l[0]=0, and SHALL clear on any CPU grant or when req_l[0]=1.
REQ-019 The starvation counter SHALL saturate at STARVE_MAX.
REQ-020 In GRANT, dbbz_l=0 SHALL move the FSM to BUSY; all grant_l SHALL go high on that same edge.
REQ-021 In GRANT, when the winner releases its request (req_l[winner]=1) before dbbz_l goes low, the FSM SHALL return to IDLE and drop the grant; grant_tmo_h SHALL stay low.
REQ-022 In GRANT, the grant counter SHALL increment each cycle.
REQ-023 When the grant counter reaches GRANT_TMO in GRANT, the FSM SHALL go to IDLE, drop the grant and pulse grant_tmo_h for one cycle.
REQ-024 When dbbz_l=0 and req withdrawal occur in the same cycle, dbbz_l SHALL take precedence: the FSM goes to BUSY.
REQ-025 In BUSY, the busy counter SHALL increment each cycle while dbbz_l=0 or hold_l=0.
REQ-026 In BUSY, dbbz_l=1 with hold_l=1 SHALL move the FSM to DRAIN.
REQ-027 When the busy counter reaches BUSY_TMO, the FSM SHALL pulse bus_tmo_h once and go to DRAIN, regardless of dbbz_l.
REQ-028 DRAIN SHALL last exactly one cycle with all grants high, then go to IDLE; this guarantees one dead cycle between tenures.
REQ-029 Both counters SHALL clear on entry to GRANT and on entry to BUSY.
REQ-030 Both counters SHALL be 8 bits wide and SHALL never wrap.
REQ-031 owner_h SHALL load the winner on entry to GRANT and hold it otherwise.
REQ-032 At most one grant_l bit SHALL be low in any cycle.
REQ-033 grant_l SHALL be low only in GRANT.

Reset
REQ-034 Asserting mseq_init_h at any time SHALL immediately force: FSM=IDLE, grant_l=4'b1111, arb_busy_h=0, grant_tmo_h=0, bus_tmo_h=0, owner_h=0, all counters=0.
REQ-035 A reset asserted mid-tenure SHALL drop the grant with no timeout pulse.
REQ-036 After reset deasserts, the first arbitration SHALL occur at the first rising edge on which REQ-015 holds.

Structure
REQ-037 Package cmi_arb_pkg SHALL hold the state encoding, the requester-index constants (CPU=0) and the default values of GRANT_TMO, BUSY_TMO and STARVE_MAX.
REQ-038 Priority selection, including the starvation override, SHALL be a combinational sub-module cmi_arb_prio with inputs req_l and starve_h and output winner[1:0] plus a valid bit.
REQ-039 All other logic SHALL reside in cmi_bus_arbiter.

Verification
REQ-040 Bench: req_l=4'b1010, bus idle -> next edge grant_l=4'b1011, owner_h=2; dbbz_l low 1 cycle later -> grant_l=4'b1111, arb_busy_h=1.
REQ-041 Bench: grant to requester 1, dbbz_l held high 15 cycles -> grant_tmo_h pulses once, FSM returns to IDLE, grant_l=4'b1111.
REQ-042 Bench: dbbz_l held low 256 cycles after entering BUSY -> bus_tmo_h pulses once, DRAIN follows, then IDLE.
REQ-043 Bench: req_l[3] and req_l[0] continuously low for 9 tenures -> grants 3 eight times, then the ninth grant goes to 0 (grant_l=4'b1110).
REQ-044 Bench: hold_l=0 while dbbz_l=1 in BUSY -> stays in BUSY; hold_l=1 -> DRAIN, one cycle with all grants high, next grant one cycle later.
REQ-045 Bench: mseq_init_h pulsed in GRANT and again in BUSY -> outputs reach reset values before the next clock edge; no timeout pulse.
